muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit that runs beside the single-cycle ALU in the execute stage. It handles signed and unsigned multiply and divide on WIDTH-bit two's-complement operands. Results are returned as a {hi, lo} pair through valid/ready handshakes on both input and output, and an in-flight operation can be cancelled for exception flush.

---
 rtl/muldiv_unit.sv | 147 ++++++++++++++
 tb/tb_muldiv_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with valid/ready on both sides and flush cancel.
// Optional MULDIV_FAST_MUL_EN: MULT/MULTU complete through a single-cycle multiplier.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cancel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic               is_mul, bad_op, dz, neg_res, neg_rem;
  logic [WIDTH-1:0]   opnd;          // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   dividend_raw;
  logic [2*WIDTH-1:0] acc;

  // request decode
  logic             req_mult, req_multu, req_div, req_divu, req_signed;
  logic             s1_neg, s2_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign req_mult   = (op == 4'b1000);
  assign req_multu  = (op == 4'b0100);
  assign req_div    = (op == 4'b0010);
  assign req_divu   = (op == 4'b0001);
  assign req_signed = req_mult | req_div;
  assign s1_neg     = req_signed & src1[WIDTH-1];
  assign s2_neg     = req_signed & src2[WIDTH-1];
  assign a_mag      = s1_neg ? (~src1 + 1'b1) : src1;
  assign b_mag      = s2_neg ? (~src2 + 1'b1) : src2;

  // restoring divide step: acc = {remainder, dividend/quotient}
  logic [WIDTH:0]     shifted, diff;
  logic               qbit;
  logic [2*WIDTH-1:0] div_next, mul_next, step_next;

  assign shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign diff     = shifted - {1'b0, opnd};
  assign qbit     = ~diff[WIDTH];
  assign div_next = {(qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]), acc[WIDTH-2:0], qbit};

`ifdef MULDIV_FAST_MUL_EN
  assign mul_next = {{WIDTH{1'b0}}, opnd} * {{WIDTH{1'b0}}, acc[WIDTH-1:0]};
`else
  // shift-add step: acc = {partial product, remaining multiplier bits}
  logic [WIDTH:0] mul_sum;
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};
`endif

  assign step_next = is_mul ? mul_next : div_next;

  // sign correction and special cases applied on the final step
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, res_hi, res_lo;

  assign prod_s = neg_res ? (~step_next + 1'b1) : step_next;
  assign quo_s  = neg_res ? (~step_next[WIDTH-1:0] + 1'b1) : step_next[WIDTH-1:0];
  assign rem_s  = neg_rem ? (~step_next[2*WIDTH-1:WIDTH] + 1'b1) : step_next[2*WIDTH-1:WIDTH];

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    if (bad_op) begin
      res_hi = '0;
      res_lo = '0;
    end else if (is_mul) begin
      res_hi = prod_s[2*WIDTH-1:WIDTH];
      res_lo = prod_s[WIDTH-1:0];
    end else if (dz) begin
      res_hi = dividend_raw;
      res_lo = '1;
    end else begin
      res_hi = rem_s;
      res_lo = quo_s;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      count        <= '0;
      is_mul       <= 1'b0;
      bad_op       <= 1'b0;
      dz           <= 1'b0;
      neg_res      <= 1'b0;
      neg_rem      <= 1'b0;
      opnd         <= '0;
      dividend_raw <= '0;
      acc          <= '0;
      hi           <= '0;
      lo           <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid && !cancel) begin
          is_mul       <= req_mult | req_multu;
          bad_op       <= !(req_mult | req_multu | req_div | req_divu);
          dz           <= (req_div | req_divu) && (src2 == '0);
          neg_res      <= s1_neg ^ s2_neg;
          neg_rem      <= s1_neg;
          dividend_raw <= src1;
          opnd         <= (req_mult | req_multu) ? a_mag : b_mag;
          acc          <= {{WIDTH{1'b0}}, ((req_mult | req_multu) ? b_mag : a_mag)};
`ifdef MULDIV_FAST_MUL_EN
          count        <= (req_mult | req_multu) ? CW'(1) : CW'(WIDTH);
`else
          count        <= CW'(WIDTH);
`endif
          state        <= BUSY;
        end
        BUSY: if (cancel) begin
          state <= IDLE;
        end else begin
          acc   <= step_next;
          count <= count - 1'b1;
          if (count == CW'(1)) begin
            hi    <= res_hi;
            lo    <= res_lo;
            state <= DONE;
          end
        end
        DONE: if (cancel || out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, random unsigned ops against a
// behavioural model, and hand sequences for backpressure, cancel and async reset.
module tb_muldiv_unit;
  localparam int W = 32;
  localparam logic [3:0] MULT = 4'b1000, MULTU = 4'b0100, DIV = 4'b0010, DIVU = 4'b0001;

  logic         clk = 1'b0, resetn = 1'b0, cancel = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] src1 = '0, src2 = '0;
  logic         in_ready, out_valid, busy;
  logic [W-1:0] hi, lo;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .cancel(cancel), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src1(src1), .src2(src2), .out_valid(out_valid), .out_ready(out_ready),
    .hi(hi), .lo(lo), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [W-1:0] hi, lo; } res_t;
  typedef struct { logic [3:0] op; logic [W-1:0] a, b, hi, lo; } vec_t;

  res_t sb[$];
  int   checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [3:0] o);
`ifdef MULDIV_FAST_MUL_EN
    if (o == MULT || o == MULTU) return 1;
`endif
    return W;
  endfunction

  // drive one request; it is accepted on the next edge (caller ensures IDLE)
  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input bit push);
    res_t r;
    op = o; src1 = a; src2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 4'($urandom); src1 = $urandom; src2 = $urandom;
    r.hi = eh; r.lo = el;
    if (push) sb.push_back(r);
  endtask

  // wait (bounded) for out_valid, check latency and scoreboard head
  task automatic collect(input string name, input int lat, input bit consume);
    int   n = 0;
    res_t e;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_latency"}, 64'(n), 64'(lat));
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      chk({name, "_hi"}, 64'(hi), 64'(e.hi));
      chk({name, "_lo"}, 64'(lo), 64'(e.lo));
    end
    if (consume) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({name, "_idle"}, 64'(in_ready), 64'd1);
    end
  endtask

  vec_t vt[12];

  initial begin
    vt[0]  = '{MULT,  32'hFFFFFFFD, 32'd5,          32'hFFFFFFFF, 32'hFFFFFFF1};
    vt[1]  = '{DIVU,  32'd100,      32'd7,          32'd2,        32'd14};
    vt[2]  = '{DIV,   32'hFFFFFFF9, 32'd2,          32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[3]  = '{DIV,   32'h80000000, 32'hFFFFFFFF,   32'd0,        32'h80000000};
    vt[4]  = '{DIVU,  32'h1234,     32'd0,          32'h1234,     32'hFFFFFFFF};
    vt[5]  = '{DIV,   32'hFFFFFFF9, 32'd0,          32'hFFFFFFF9, 32'hFFFFFFFF};
    vt[6]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,   32'hFFFFFFFE, 32'h00000001};
    vt[7]  = '{MULT,  32'hFFFFFFFF, 32'hFFFFFFFF,   32'd0,        32'd1};
    vt[8]  = '{DIV,   32'd7,        32'hFFFFFFFE,   32'd1,        32'hFFFFFFFD};
    vt[9]  = '{MULT,  32'h80000000, 32'h80000000,   32'h40000000, 32'd0};
    vt[10] = '{4'b0000, 32'd9,      32'd3,          32'd0,        32'd0};
    vt[11] = '{4'b1100, 32'd9,      32'd3,          32'd0,        32'd0};

    // reset state
    #12;
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_hi",        64'(hi),        64'd0);
    chk("rst_lo",        64'(lo),        64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      issue(vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, 1'b1);
      collect($sformatf("vec%0d", i), exp_lat(vt[i].op), 1'b1);
    end

    // random unsigned ops against a behavioural model
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] a, b;
      logic [63:0]  p;
      a = $urandom;
      if (i % 2 == 0) begin
        b = $urandom;
        p = {32'd0, a} * {32'd0, b};
        issue(MULTU, a, b, p[63:32], p[31:0], 1'b1);
        collect($sformatf("rnd_mulu%0d", i), exp_lat(MULTU), 1'b1);
      end else begin
        b = 32'($urandom_range(1, 1000));
        issue(DIVU, a, b, a % b, a / b, 1'b1);
        collect($sformatf("rnd_divu%0d", i), exp_lat(DIVU), 1'b1);
      end
    end

    // output backpressure
    issue(DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    collect("bp", W, 1'b0);
    repeat (10) begin @(posedge clk); #1; end
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    chk("bp_in_ready",  64'(in_ready),  64'd0);
    chk("bp_hold_hi",   64'(hi),        64'd2);
    chk("bp_hold_lo",   64'(lo),        64'd14);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_idle",  64'(in_ready),  64'd1);
    chk("bp_release_valid", 64'(out_valid), 64'd0);
    issue(MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b1);
    chk("bp_next_accept", 64'(busy), 64'd1);
    collect("bp_next", exp_lat(MULT), 1'b1);

    // cancel in BUSY: result registers keep the previous result
    issue(DIVU, 32'h1234, 32'd3, '0, '0, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    chk("cancel_out_valid", 64'(out_valid), 64'd0);
    chk("cancel_idle",      64'(in_ready),  64'd1);
    chk("cancel_hi",        64'(hi),        64'hFFFFFFFF);
    chk("cancel_lo",        64'(lo),        64'hFFFFFFF1);
    repeat (40) begin @(posedge clk); #1; end
    chk("cancel_no_result", 64'(out_valid), 64'd0);

    // cancel in IDLE blocks acceptance
    op = DIVU; src1 = 32'd50; src2 = 32'd5; in_valid = 1'b1; cancel = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; cancel = 1'b0;
    chk("cancel_idle_no_accept", 64'(busy), 64'd0);

    // asynchronous reset mid-operation
    issue(DIVU, 32'd1000, 32'd3, '0, '0, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    chk("pre_reset_busy", 64'(busy), 64'd1);
    resetn = 1'b0;
    #1;
    chk("arst_in_ready",  64'(in_ready),  64'd1);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_hi",        64'(hi),        64'd0);
    chk("arst_lo",        64'(lo),        64'd0);
    #2 resetn = 1'b1;
    @(posedge clk); #1;
    issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1);
    collect("post_reset", exp_lat(MULTU), 1'b1);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
